// File: rtl/cla_slice_sequencer_if.sv
// Operand/result bus of the sliced wide adder.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both 1; the
// sender holds its payload stable while valid is high and ready is low; ready may depend on state only.
interface cla_slice_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             zero;
    logic             busy;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, zero, busy
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, zero, busy
    );
endinterface

// File: rtl/cla_slice_sequencer.sv
// Wide adder built from one 4-bit carry-lookahead cell reused once per slice,
// LSB slice first, with the slice carry chained through a register.
module carrylook (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic       cout_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c[0] = cin_i;
        c[1] = g[0] | (p[0] & cin_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin_i);
        s_o    = p ^ c[3:0];
        cout_o = c[4];
    end
endmodule

module cla_slice_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cla_slice_sequencer_if.slave   bus,
    output logic [1:0]             dbg_state_o
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;

    logic [3:0]         slice_a;
    logic [3:0]         slice_b;
    logic [3:0]         slice_s;
    logic               slice_cout;
    logic               last_slice;
    logic               in_ready_w;
    logic               out_valid_w;

    assign slice_a    = a_q[{idx_q, 2'b00} +: 4];
    assign slice_b    = b_q[{idx_q, 2'b00} +: 4];
    assign last_slice = (idx_q == IDXW'(NSLICE - 1));

    carrylook u_cla (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .s_o    (slice_s),
        .cout_o (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        in_ready_w  = 1'b0;
        out_valid_w = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready_w = 1'b1;
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[{idx_q, 2'b00} +: 4] = slice_s;
                carry_d                    = slice_cout;
                if (last_slice) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                out_valid_w = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    // After the last slice the carry register holds the MSB carry, so it doubles as cout.
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.sum       = sum_q;
    assign bus.cout      = carry_q;
    assign bus.zero      = out_valid_w && (sum_q == '0);
    assign bus.busy      = (state_q != ST_IDLE);
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Randomized and directed bench for the sliced wide adder, WIDTH=16 plus a WIDTH=4 instance.
module tb_cla_slice_sequencer;
  localparam int W  = 16;
  localparam int NS = W / 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cla_slice_sequencer_if #(.WIDTH(W)) bus ();
  cla_slice_sequencer_if #(.WIDTH(4)) bus4 ();
  logic [1:0] dbg;
  logic [1:0] dbg4;

  cla_slice_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg)
  );

  cla_slice_sequencer #(.WIDTH(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus4),
    .dbg_state_o (dbg4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: expected {cout,sum} of every accepted transaction
  logic [W:0] exp_q[$];
  int  m_phase = 0;   // 0 idle, 1 computing, 2 presenting
  int  m_cnt   = 0;
  bit  m_clean = 1'b1;
  bit  m_en    = 1'b0;

  always @(negedge clk) begin
    if (m_en) begin
      logic [W:0] e;
      logic [W:0] nv;
      chk("in_ready", bus.in_ready, m_phase == 0);
      chk("out_valid", bus.out_valid, m_phase == 2);
      chk("busy", bus.busy, m_phase != 0);
      if (m_phase == 2) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result_pending: no expected result queued at %0t", $time);
        end else begin
          e = exp_q[0];
          chk("sum", bus.sum, e[W-1:0]);
          chk("cout", bus.cout, e[W]);
          chk("zero", bus.zero, e[W-1:0] == '0);
        end
      end else begin
        chk("zero_unqualified", bus.zero, 0);
      end
      if (m_clean) begin
        chk("sum_after_reset", bus.sum, 0);
        chk("cout_after_reset", bus.cout, 0);
      end
      // advance the model across the coming edge
      if (!rst_n) begin
        m_phase = 0;
        m_clean = 1'b1;
        exp_q.delete();
      end else begin
        case (m_phase)
          0: if (bus.in_valid) begin
               nv = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin};
               exp_q.push_back(nv);
               m_phase = 1;
               m_cnt   = NS;
               m_clean = 1'b0;
             end
          1: begin
               m_cnt--;
               if (m_cnt == 0) m_phase = 2;
             end
          default: if (bus.out_ready) begin
               void'(exp_q.pop_front());
               m_phase = 0;
             end
        endcase
      end
    end
  end

  // driver: one transaction from IDLE; hold = cycles out_ready stays low after out_valid
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input int hold, output logic [W-1:0] s, output logic co,
                         output logic z, output int lat);
    bus.out_ready = (hold == 0);
    bus.a = a; bus.b = b; bus.cin = c; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_within_budget", bus.out_valid, 1);
    s = bus.sum; co = bus.cout; z = bus.zero;
    if (hold > 0) begin
      repeat (hold) begin
        bus.in_valid = 1'($urandom);
        bus.a = W'($urandom); bus.b = W'($urandom);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  task automatic run_txn4(input logic [3:0] a, input logic [3:0] b, input logic c,
                          output logic [3:0] s, output logic co, output int lat);
    bus4.out_ready = 1'b0;
    bus4.a = a; bus4.b = b; bus4.cin = c; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    lat = 0;
    while (!bus4.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w4_out_valid_within_budget", bus4.out_valid, 1);
    s = bus4.sum; co = bus4.cout;
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    chk("w4_idle_after_accept", bus4.in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] s;
    logic co;
    logic z;
    int lat;
    logic [W:0] ref_v;
    logic [3:0] s4;
    logic [4:0] ref4;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_en = 1'b1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_zero", bus.zero, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    run_txn(16'h0001, 16'h0003, 1'b0, 0, s, co, z, lat);
    chk("t1_latency", lat, 4);
    chk("t1_sum", s, 16'h0004);
    chk("t1_cout", co, 0);
    chk("t1_zero", z, 0);

    run_txn(16'hFFFF, 16'h0001, 1'b0, 0, s, co, z, lat);
    chk("t2_sum", s, 16'h0000);
    chk("t2_cout", co, 1);
    chk("t2_zero", z, 1);

    run_txn(16'h1234, 16'h4321, 1'b1, 1, s, co, z, lat);
    chk("t3_sum", s, 16'h5556);
    chk("t3_cout", co, 0);

    run_txn(16'hABCD, 16'h1111, 1'b0, 5, s, co, z, lat);
    chk("t4_sum", s, 16'hBCDE);
    chk("t4_cout", co, 0);

    // reset two cycles into the computation
    bus.a = 16'h7777; bus.b = 16'h8888; bus.cin = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_in_ready", bus.in_ready, 1);
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_sum", bus.sum, 0);
    run_txn(16'h9999, 16'h9999, 1'b0, 1, s, co, z, lat);
    chk("t5b_sum", s, 16'h3332);
    chk("t5b_cout", co, 1);

    // WIDTH=4 instance
    run_txn4(4'h9, 4'h9, 1'b0, s4, co, lat);
    chk("t6_latency", lat, 1);
    chk("t6_sum", s4, 4'h2);
    chk("t6_cout", co, 1);
    for (int i = 0; i < 20; i++) begin
      logic [3:0] ra, rb;
      logic rc;
      ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
      ref4 = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
      run_txn4(ra, rb, rc, s4, co, lat);
      chk("w4_rand_sum", s4, ref4[3:0]);
      chk("w4_rand_cout", co, ref4[4]);
      chk("w4_rand_latency", lat, 1);
    end

    // randomized traffic on the wide instance
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      int h;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (i % 10 == 0) rb = ~ra;
      h = $urandom_range(0, 3);
      ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_txn(ra, rb, rc, h, s, co, z, lat);
      chk("rand_latency", lat, NS);
      chk("rand_sum", s, ref_v[W-1:0]);
      chk("rand_cout", co, ref_v[W]);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
